// File: rtl/scpu_pkg.sv
// Shared scpu datapath definitions: selector modes and a one-hot index helper.
package scpu_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Index of the set bit of a one-hot vector of up to 16 channels; 0 if none set.
    function automatic int onehot_to_idx(input logic [15:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr wins, wrapping modulo N_CH.
module rr_arbiter
    import scpu_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W:0]  sh;
    logic [N_CH-1:0] rot;
    logic [N_CH-1:0] first;

    // Rotate so channel ptr+1 sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        sh    = {1'b0, ptr} + (SEL_W+1)'(1);
        rot   = N_CH'({req, req} >> sh);
        first = rot & (~rot + 1'b1);
        gnt   = N_CH'(({first, first} << sh) >> N_CH);
        idx   = SEL_W'(onehot_to_idx(16'(gnt)));
    end

endmodule

// File: rtl/mux_rr_reg.sv
// N-channel selector (explicit select or round-robin) feeding a valid/ready output register.
module mux_rr_reg
    import scpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_CH  = 4,
    parameter int MODE  = 0,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch
);

    logic             load;
    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] win_idx;
    logic [WIDTH-1:0] win_data;

    assign load     = ~out_valid | out_ready;
    assign in_ready = grant & {N_CH{load}};

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] rr_ptr;

            rr_arbiter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_arb (
                .req (in_valid),
                .ptr (rr_ptr),
                .gnt (grant),
                .idx (win_idx)
            );

            // Pointer only moves on an accepted beat so stalls keep the rotation intact.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)             rr_ptr <= SEL_W'(N_CH - 1);
                else if (load && |grant) rr_ptr <= win_idx;
            end
        end else begin : g_sel
            always_comb begin
                grant   = '0;
                win_idx = sel;
                if (int'(sel) < N_CH && in_valid[sel]) grant[sel] = 1'b1;
            end
        end
    endgenerate

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) win_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load) begin
            out_valid <= |grant;
            if (|grant) begin
                out_data <= win_data;
                out_ch   <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Scoreboard bench: explicit-select (4 and 3 channels) and round-robin instances of mux_rr_reg.
module tb_mux_rr_reg;

    typedef struct {
        logic [3:0]  ch;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // dut0: MODE 0, 4 channels
    logic [3:0]   iv0, ir0;
    logic [127:0] id0;
    logic [1:0]   sel0, oc0;
    logic         or0, ov0;
    logic [31:0]  od0;
    // dut1: MODE 0, 3 channels
    logic [2:0]   iv1, ir1;
    logic [95:0]  id1;
    logic [1:0]   sel1, oc1;
    logic         or1, ov1;
    logic [31:0]  od1;
    // dut2: MODE 1, 4 channels
    logic [3:0]   iv2, ir2;
    logic [127:0] id2;
    logic [1:0]   sel2, oc2;
    logic         or2, ov2;
    logic [31:0]  od2;

    mux_rr_reg #(.WIDTH(32), .N_CH(4), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(id0), .sel(sel0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_ch(oc0));
    mux_rr_reg #(.WIDTH(32), .N_CH(3), .MODE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1), .sel(sel1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_ch(oc1));
    mux_rr_reg #(.WIDTH(32), .N_CH(4), .MODE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_data(id2), .sel(sel2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_ch(oc2));

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q2[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push0(input int ch, input logic [31:0] d);
        exp_t e;
        e.ch = 4'(ch); e.data = d;
        q0.push_back(e);
    endtask

    task automatic push2(input int ch, input logic [31:0] d);
        exp_t e;
        e.ch = 4'(ch); e.data = d;
        q2.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: a beat is consumed when out_valid & out_ready are seen mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ov0 && or0) begin
            if (q0.size() == 0) chk("dut0_unexpected_beat", {32'd0, od0}, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                exp_t e;
                e = q0.pop_front();
                chk("dut0_data", {32'd0, od0}, {32'd0, e.data});
                chk("dut0_ch", {62'd0, oc0}, {60'd0, e.ch});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ov2 && or2) begin
            if (q2.size() == 0) chk("dut2_unexpected_beat", {32'd0, od2}, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                exp_t e;
                e = q2.pop_front();
                chk("dut2_data", {32'd0, od2}, {32'd0, e.data});
                chk("dut2_ch", {62'd0, oc2}, {60'd0, e.ch});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        iv0 = '0; id0 = '0; sel0 = '0; or0 = 1'b0;
        iv1 = '0; id1 = '0; sel1 = '0; or1 = 1'b0;
        iv2 = '0; id2 = '0; sel2 = '0; or2 = 1'b0;
        #2;
        chk("reset_ov0", ov0, 0);
        chk("reset_od0", od0, 0);
        chk("reset_ov2", ov2, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // explicit select, single beat
        sel0 = 2'd2; iv0 = 4'b0100; id0[64 +: 32] = 32'hDEADBEEF; or0 = 1'b1;
        #1 chk("sel_in_ready", ir0, 4'b0100);
        push0(2, 32'hDEADBEEF);
        tick();
        // selected channel idle, another channel valid
        iv0 = 4'b0001;
        #1 chk("sel_idle_in_ready", ir0, 0);
        tick();
        chk("sel_idle_out_valid", ov0, 0);
        iv0 = '0;

        // 3 channels: sel beyond range is never granted
        iv1 = 3'b111; id1 = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000}; or1 = 1'b1;
        sel1 = 2'd2;
        #1 chk("n3_sel2_in_ready", ir1, 3'b100);
        tick();
        chk("n3_out_valid", ov1, 1);
        chk("n3_out_ch", oc1, 2);
        chk("n3_out_data", od1, 32'h2222_2222);
        sel1 = 2'd3;
        #1 chk("n3_sel3_in_ready", ir1, 0);
        tick();
        chk("n3_sel3_out_valid", ov1, 0);

        // backpressure: held beat and in_ready stay frozen while producers toggle
        or0 = 1'b0; sel0 = 2'd1; iv0 = 4'b0010; id0[32 +: 32] = 32'h1111_1111;
        push0(1, 32'h1111_1111);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", ov0, 1);
            chk("bp_out_data", od0, 32'h1111_1111);
            chk("bp_out_ch", oc0, 1);
            sel0 = k[0] ? 2'd3 : 2'd1;
            iv0  = k[0] ? 4'b1000 : 4'b0010;
            id0[32 +: 32] = 32'h5000 + k;
            id0[96 +: 32] = 32'h6000 + k;
            #1 chk("bp_in_ready", ir0, 0);
            tick();
        end
        sel0 = 2'd3; iv0 = 4'b1000; id0[96 +: 32] = 32'h3333_3333; or0 = 1'b1;
        #1 chk("bp_release_in_ready", ir0, 4'b1000);
        push0(3, 32'h3333_3333);
        tick();
        iv0 = '0;
        tick();
        tick();

        // round robin, all channels valid
        for (int i = 0; i < 4; i++) id2[i*32 +: 32] = 32'hA000_0000 + i;
        iv2 = 4'b1111; or2 = 1'b1;
        #1 chk("rr_first_in_ready", ir2, 4'b0001);
        for (int n = 0; n < 8; n++) push2(n % 4, 32'hA000_0000 + (n % 4));
        repeat (8) tick();
        iv2 = '0;
        tick();

        // round robin, channels 0 and 3, with a stall after the first grant
        iv2 = 4'b1001;
        #1 chk("rr_wrap_in_ready", ir2, 4'b0001);
        push2(0, 32'hA000_0000);
        tick();
        or2 = 1'b0;
        #1 chk("rr_stall_in_ready", ir2, 0);
        repeat (3) begin
            tick();
            chk("rr_stall_out_ch", oc2, 0);
            chk("rr_stall_out_valid", ov2, 1);
        end
        or2 = 1'b1;
        #1 chk("rr_after_stall_in_ready", ir2, 4'b1000);
        push2(3, 32'hA000_0003);
        push2(0, 32'hA000_0000);
        tick();
        tick();
        iv2 = '0;
        tick();
        tick();

        // reset mid-stream discards the held beat asynchronously
        or0 = 1'b0; sel0 = 2'd1; iv0 = 4'b0010; id0[32 +: 32] = 32'hCAFE_F00D;
        tick();
        iv0 = '0;
        chk("pre_reset_out_valid", ov0, 1);
        chk("pre_reset_out_ch", oc0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", ov0, 0);
        chk("async_reset_out_data", od0, 0);
        chk("async_reset_out_ch", oc0, 0);
        tick();
        rst_n = 1'b1;
        tick();

        chk("q0_drained", q0.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
